median_filter_frame_ctrl: RTL and testbench



---
 rtl/median_filter_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_median_filter_frame_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_filter_frame_ctrl.sv
// Frame-synchronous enable controller for the median filter: applies enable changes only between frames,
// checks frame geometry and counts frames. Define MEDIAN_FILTER_FRAME_CTRL_WDT_EN to add an in-frame stall watchdog.
module median_filter_frame_ctrl #(
  parameter int unsigned FRAME_RES_X = 1920,
  parameter int unsigned FRAME_RES_Y = 1080,
  parameter int unsigned WDT_CYCLES  = 65536
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_req_i,
  input  logic        vid_tvalid_i,
  input  logic        vid_tready_i,
  input  logic        vid_tuser_i,
  input  logic        vid_tlast_i,
  input  logic        clr_err_i,
  output logic        filt_en_o,
  output logic        in_frame_o,
  output logic [31:0] frame_cnt_o,
  output logic        geom_err_o
);

  localparam int unsigned PX_W = (FRAME_RES_X > 1) ? $clog2(FRAME_RES_X) : 1;
  localparam int unsigned LN_W = (FRAME_RES_Y > 1) ? $clog2(FRAME_RES_Y) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(FRAME_RES_X - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(FRAME_RES_Y - 1);
  localparam logic SOF_IS_EOL = (FRAME_RES_X == 1);
  localparam logic SOF_IS_EOF = (FRAME_RES_X == 1) && (FRAME_RES_Y == 1);

  typedef enum logic {ST_WAIT_SOF, ST_IN_FRAME} state_t;

  state_t          r_state, w_state_nxt;
  logic [PX_W-1:0] r_px, w_px_nxt;
  logic [LN_W-1:0] r_line, w_line_nxt;
  logic            r_filt_en, w_filt_en_nxt;
  logic            r_in_frame, w_in_frame_nxt;
  logic [31:0]     r_frame_cnt, w_frame_cnt_nxt;
  logic            r_geom_err, w_geom_err_nxt;
  logic            w_hs, w_eol_exp, w_err_evt, w_eof;

`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] r_wdt, w_wdt_nxt;
`endif

  assign w_hs = vid_tvalid_i && vid_tready_i;

  // State register and all datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_WAIT_SOF;
      r_px        <= '0;
      r_line      <= '0;
      r_filt_en   <= 1'b0;
      r_in_frame  <= 1'b0;
      r_frame_cnt <= '0;
      r_geom_err  <= 1'b0;
`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
      r_wdt       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_px        <= w_px_nxt;
      r_line      <= w_line_nxt;
      r_filt_en   <= w_filt_en_nxt;
      r_in_frame  <= w_in_frame_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_geom_err  <= w_geom_err_nxt;
`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
      r_wdt       <= w_wdt_nxt;
`endif
    end
  end

  // Next-state, geometry check and output updates
  always_comb begin
    w_state_nxt     = r_state;
    w_px_nxt        = r_px;
    w_line_nxt      = r_line;
    w_filt_en_nxt   = r_filt_en;
    w_frame_cnt_nxt = r_frame_cnt;
    w_geom_err_nxt  = r_geom_err;
    w_eol_exp       = 1'b0;
    w_err_evt       = 1'b0;
    w_eof           = 1'b0;

    case (r_state)
      ST_WAIT_SOF: begin
        if (w_hs && vid_tuser_i) begin
          if (SOF_IS_EOF) begin
            w_eof = 1'b1;
          end else begin
            w_state_nxt = ST_IN_FRAME;
            w_px_nxt    = SOF_IS_EOL ? PX_W'(0) : PX_W'(1);
            w_line_nxt  = SOF_IS_EOL ? LN_W'(1) : LN_W'(0);
          end
        end else begin
          w_filt_en_nxt = en_req_i;
        end
      end
      ST_IN_FRAME: begin
        if (w_hs) begin
          w_eol_exp = (r_px == PX_LAST);
          if (vid_tuser_i || (vid_tlast_i != w_eol_exp)) begin
            w_err_evt = 1'b1;
          end else if (w_eol_exp) begin
            w_px_nxt = '0;
            if (r_line == LN_LAST) w_eof = 1'b1;
            else                   w_line_nxt = r_line + LN_W'(1);
          end else begin
            w_px_nxt = r_px + PX_W'(1);
          end
        end
`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
        else if (r_wdt == WDT_LAST) begin
          w_err_evt = 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_WAIT_SOF;
    endcase

    // Pending enable request lands on the same edge that closes the frame
    if (w_eof) begin
      w_state_nxt     = ST_WAIT_SOF;
      w_px_nxt        = '0;
      w_line_nxt      = '0;
      w_frame_cnt_nxt = r_frame_cnt + 32'd1;
      w_filt_en_nxt   = en_req_i;
    end
    if (w_err_evt) begin
      w_state_nxt = ST_WAIT_SOF;
      w_px_nxt    = '0;
      w_line_nxt  = '0;
    end

    if (clr_err_i) w_geom_err_nxt = 1'b0;
    if (w_err_evt) w_geom_err_nxt = 1'b1;

    w_in_frame_nxt = (w_state_nxt == ST_IN_FRAME);
  end

`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
  always_comb begin
    w_wdt_nxt = '0;
    if ((r_state == ST_IN_FRAME) && (w_state_nxt == ST_IN_FRAME) && !w_hs)
      w_wdt_nxt = r_wdt + WDT_W'(1);
  end
`endif

  assign filt_en_o   = r_filt_en;
  assign in_frame_o  = r_in_frame;
  assign frame_cnt_o = r_frame_cnt;
  assign geom_err_o  = r_geom_err;

endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// Self-checking bench for median_filter_frame_ctrl (4x3 frames, watchdog of 8 cycles when the macro is defined):
// constant vector table, hand-written corner sequences and random traffic against a beat-position model.
module tb_median_filter_frame_ctrl;

  localparam int unsigned RX  = 4;
  localparam int unsigned RY  = 3;
  localparam int unsigned WDT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, v, r, u, l, clr;
  logic        filt_en, in_frame, geom_err;
  logic [31:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: frame position counted as a flat beat index within the frame
  logic        m_in, m_filt, m_err;
  logic [31:0] m_cnt;
  int          m_pos, m_stall;

  typedef struct {
    logic en, v, r, u, l, clr;
    logic ex_filt, ex_in, ex_err;
    logic [31:0] ex_cnt;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  median_filter_frame_ctrl #(
    .FRAME_RES_X(RX), .FRAME_RES_Y(RY), .WDT_CYCLES(WDT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_req_i(en),
    .vid_tvalid_i(v), .vid_tready_i(r), .vid_tuser_i(u), .vid_tlast_i(l),
    .clr_err_i(clr),
    .filt_en_o(filt_en), .in_frame_o(in_frame), .frame_cnt_o(frame_cnt), .geom_err_o(geom_err)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_in = 0; m_filt = 0; m_err = 0; m_cnt = 0; m_pos = 0; m_stall = 0;
  endtask

  task automatic m_update();
    logic hs, err_now, eof;
    hs = v && r; err_now = 0; eof = 0;
    if (!m_in) begin
      if (hs && u) begin
        m_in = 1; m_pos = 1; m_stall = 0;
        if (RX * RY == 1) eof = 1;
      end else m_filt = en;
    end else if (hs) begin
      m_stall = 0;
      if (u || (l != ((m_pos % RX) == RX - 1))) err_now = 1;
      else if (m_pos == RX * RY - 1) eof = 1;
      else m_pos++;
    end else begin
`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
      if (m_stall == WDT - 1) err_now = 1;
      else m_stall++;
`endif
    end
    if (eof) begin m_in = 0; m_cnt++; m_filt = en; end
    if (clr) m_err = 0;
    if (err_now) begin m_err = 1; m_in = 0; end
    if (!m_in) m_stall = 0;
  endtask

  task automatic step(input string tag);
    m_update();
    @(posedge clk);
    #1;
    chk({tag, ".filt_en"},  32'(filt_en),  32'(m_filt));
    chk({tag, ".in_frame"}, 32'(in_frame), 32'(m_in));
    chk({tag, ".geom_err"}, 32'(geom_err), 32'(m_err));
    chk({tag, ".frame_cnt"}, frame_cnt, m_cnt);
  endtask

  task automatic drive(input logic i_en, i_v, i_r, i_u, i_l, i_clr);
    en = i_en; v = i_v; r = i_r; u = i_u; l = i_l; clr = i_clr;
  endtask

  function automatic void add_vec(input logic a_en, a_v, a_r, a_u, a_l, a_clr,
                                  input logic e_filt, e_in, e_err, input logic [31:0] e_cnt);
    vec_t t;
    t.en = a_en; t.v = a_v; t.r = a_r; t.u = a_u; t.l = a_l; t.clr = a_clr;
    t.ex_filt = e_filt; t.ex_in = e_in; t.ex_err = e_err; t.ex_cnt = e_cnt;
    tbl.push_back(t);
  endfunction

  // Sends one full well-formed frame with tready held high
  task automatic good_frame(input string tag);
    for (int b = 1; b <= RX * RY; b++) begin
      drive(en, 1, 1, b == 1, (b % RX) == 0, 0);
      step(tag);
    end
    drive(en, 0, 1, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("reset.filt_en", 32'(filt_en), 32'd0);
    chk("reset.in_frame", 32'(in_frame), 32'd0);
    chk("reset.geom_err", 32'(geom_err), 32'd0);
    chk("reset.frame_cnt", frame_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle enable, mid-frame request, early tlast, clear
    add_vec(0, 0, 1, 0, 0, 0,  0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 0,  1, 0, 0, 0);
    add_vec(0, 0, 1, 0, 0, 0,  0, 0, 0, 0);
    for (int b = 1; b <= 12; b++)
      add_vec(b >= 5, 1, 1, b == 1, (b % 4) == 0, 0,  b == 12, b != 12, 0, 32'(b == 12));
    add_vec(1, 0, 1, 0, 0, 0,  1, 0, 0, 1);
    add_vec(1, 1, 1, 1, 0, 0,  1, 1, 0, 1);
    add_vec(1, 1, 1, 0, 0, 0,  1, 1, 0, 1);
    add_vec(1, 1, 1, 0, 1, 0,  1, 0, 1, 1);
    add_vec(0, 0, 1, 0, 0, 0,  0, 0, 1, 1);
    add_vec(0, 0, 1, 0, 0, 1,  0, 0, 0, 1);
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].r, tbl[i].u, tbl[i].l, tbl[i].clr);
      step("tbl_model");
      chk($sformatf("tbl[%0d].filt_en", i), 32'(filt_en), 32'(tbl[i].ex_filt));
      chk($sformatf("tbl[%0d].in_frame", i), 32'(in_frame), 32'(tbl[i].ex_in));
      chk($sformatf("tbl[%0d].geom_err", i), 32'(geom_err), 32'(tbl[i].ex_err));
      chk($sformatf("tbl[%0d].frame_cnt", i), frame_cnt, tbl[i].ex_cnt);
    end

    // Error stays sticky across a good frame; clear and new error in the same cycle keeps it set
    drive(0, 1, 1, 1, 0, 0); step("err2_sof");
    drive(0, 1, 1, 0, 1, 0); step("err2_early");
    good_frame("err2_good");
    chk("sticky.geom_err", 32'(geom_err), 32'd1);
    chk("sticky.frame_cnt", frame_cnt, 32'd2);
    drive(0, 1, 1, 1, 0, 1); step("clr_sof");
    drive(0, 1, 1, 0, 1, 1); step("clr_and_err");
    chk("clr_vs_err.geom_err", 32'(geom_err), 32'd1);
    drive(0, 0, 1, 0, 0, 1); step("clr_only");
    chk("clr_only.geom_err", 32'(geom_err), 32'd0);

    // Backpressure: tready toggles, tvalid held
    begin
      int b;
      b = 1;
      for (int c = 0; b <= RX * RY; c++) begin
        drive(1, 1, (c % 2) == 0, b == 1, (b % RX) == 0, 0);
        step("bp");
        if ((c % 2) == 0) b++;
      end
      chk("bp.frame_cnt", frame_cnt, 32'd3);
      chk("bp.geom_err", 32'(geom_err), 32'd0);
    end

    // Mid-frame tuser, tail of the frame ignored, next SOF accepted
    for (int b = 1; b <= RX * RY; b++) begin
      drive(0, 1, 1, (b == 1) || (b == 7), (b % RX) == 0, 0);
      step("tuser7");
      if (b == 7) chk("tuser7.geom_err", 32'(geom_err), 32'd1);
    end
    chk("tuser7.frame_cnt", frame_cnt, 32'd3);
    good_frame("after_tuser");
    chk("after_tuser.frame_cnt", frame_cnt, 32'd4);

    // Stall inside a frame
    drive(0, 1, 1, 1, 0, 1); step("stall_sof");
`ifdef MEDIAN_FILTER_FRAME_CTRL_WDT_EN
    for (int c = 0; c < WDT; c++) begin
      drive(0, 0, 1, 0, 0, 0); step("stall");
    end
    chk("wdt.geom_err", 32'(geom_err), 32'd1);
    chk("wdt.in_frame", 32'(in_frame), 32'd0);
`else
    for (int c = 0; c < 100; c++) begin
      drive(0, 0, 1, 0, 0, 0); step("stall");
    end
    chk("nowdt.geom_err", 32'(geom_err), 32'd0);
    chk("nowdt.in_frame", 32'(in_frame), 32'd1);
`endif

    // Random traffic with mostly correct tlast
    for (int c = 0; c < 3000; c++) begin
      logic exp_eol;
      exp_eol = m_in && ((m_pos % RX) == RX - 1);
      drive(($urandom_range(0, 19) == 0) ? ~en : en,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            m_in ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 49) == 0) ? ~exp_eol : exp_eol,
            $urandom_range(0, 29) == 0);
      step("rand");
    end

    // Asynchronous reset mid-frame
    drive(1, 1, 1, 1, 0, 0); step("rst_sof");
    drive(1, 1, 1, 0, 0, 0); step("rst_b2");
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_rst.filt_en", 32'(filt_en), 32'd0);
    chk("async_rst.in_frame", 32'(in_frame), 32'd0);
    chk("async_rst.geom_err", 32'(geom_err), 32'd0);
    chk("async_rst.frame_cnt", frame_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0, 0); step("post_rst");
    good_frame("post_rst_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
